// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encoding and sizing constants for the instruction memory loader
package imem_pkg;

   localparam int HDR_BYTES   = 4;
   localparam int IMEM_BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      CKS,
      DONE,
      ERR
   } state_e;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream writer for the instruction memory, holds the CPU until loaded
// Optional payload XOR trailer check: define IMEM_LOADER_CKSUM_EN.
module imem_loader
   import imem_pkg::*;
#(
   parameter int                   PC_WIDTH  = 32,
   parameter int                   M_STACK   = 16384,
   parameter int                   BYTE_W    = IMEM_BYTE_W,
   parameter logic [PC_WIDTH-1:0]  BASE_ADDR = '0
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [BYTE_W-1:0]   s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic                wr_en,
   output logic [PC_WIDTH-1:0] wr_addr,
   output logic [BYTE_W-1:0]   wr_data,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                cpu_hold
);

`ifdef IMEM_LOADER_CKSUM_EN
   localparam state_e PAYLOAD_END = CKS;
`else
   localparam state_e PAYLOAD_END = DONE;
`endif

   state_e              state_q, state_d;
   logic [31:0]         len_q;
   logic [31:0]         cnt_q;
   logic                s_ready_q, wr_en_q, busy_q, done_q, err_q, hold_q;
   logic [PC_WIDTH-1:0] wr_addr_q;
   logic [BYTE_W-1:0]   wr_data_q;
   logic                accept;
   logic [31:0]         hdr_len;
   logic                active_d;
`ifdef IMEM_LOADER_CKSUM_EN
   logic [BYTE_W-1:0]   cks_q;
`endif

   assign accept   = s_valid && s_ready_q;
   // Full length as it will be once the final header byte lands.
   assign hdr_len  = {s_data[7:0], len_q[23:0]};
   assign active_d = (state_d == HDR) || (state_d == DATA) || (state_d == CKS);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: if (start) state_d = HDR;
         HDR: begin
            if (accept && cnt_q == 32'(HDR_BYTES - 1)) begin
               if (hdr_len == 32'd0)
                  state_d = PAYLOAD_END;
               else if (hdr_len > 32'(M_STACK) || hdr_len[1:0] != 2'b00)
                  state_d = ERR;
               else
                  state_d = DATA;
            end
         end
         DATA: if (accept && cnt_q == len_q - 32'd1) state_d = PAYLOAD_END;
`ifdef IMEM_LOADER_CKSUM_EN
         CKS: if (accept) state_d = (s_data == cks_q) ? DONE : ERR;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         s_ready_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         hold_q    <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
         cks_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         s_ready_q <= active_d;
         busy_q    <= active_d;
         done_q    <= (state_d == DONE);
         err_q     <= (state_d == ERR);
         hold_q    <= (state_d != DONE);
         wr_en_q   <= 1'b0;
         if (state_q != HDR && state_d == HDR) begin
            len_q <= '0;
            cnt_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            cks_q <= '0;
`endif
         end else if (accept) begin
            // The counter restarts on every state change so DATA sees k from 0.
            cnt_q <= (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
            if (state_q == HDR)
               len_q[{cnt_q[1:0], 3'b000} +: 8] <= s_data[7:0];
            if (state_q == DATA) begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= BASE_ADDR + PC_WIDTH'(cnt_q);
               wr_data_q <= s_data;
`ifdef IMEM_LOADER_CKSUM_EN
               cks_q     <= cks_q ^ s_data;
`endif
            end
         end
      end
   end

   assign s_ready  = s_ready_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign cpu_hold = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized frame loads checked against a frame-level reference model
module tb_imem_loader;

   localparam int MS = 16384;
   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_ready, wr_en, busy, done, err, cpu_hold;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;

   imem_loader dut (
      .clk(clk), .n_rst(n_rst), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0]  ram [0:MS-1];
   int          wr_cyc[$];
   logic [31:0] wr_a[$];
   logic [7:0]  wr_d[$];
   int          acc_cyc[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) begin
         wr_cyc.push_back(cyc);
         wr_a.push_back(wr_addr);
         wr_d.push_back(wr_data);
         if (wr_addr < MS) ram[wr_addr[13:0]] = wr_data;
      end
      if (s_valid && s_ready) acc_cyc.push_back(cyc);
   end

   function automatic bit len_ok(input logic [31:0] len);
      return (len <= 32'(MS)) && (len[1:0] == 2'b00);
   endfunction

   // Frame-level reference: what a correct loader does with this frame.
   task automatic model(input bq_t fr, output int n_acc, output int n_wr,
                        output bit e_done, output bit e_err);
      logic [31:0] len;
      logic [7:0]  x;
      len = {fr[3], fr[2], fr[1], fr[0]};
      if (!len_ok(len)) begin
         n_acc = 4; n_wr = 0; e_done = 0; e_err = 1;
      end else begin
         n_wr = int'(len);
         n_acc = 4 + int'(len);
         e_done = 1; e_err = 0;
`ifdef IMEM_LOADER_CKSUM_EN
         x = 8'h00;
         for (int k = 0; k < int'(len); k++) x ^= fr[4+k];
         n_acc++;
         e_done = (fr[4+int'(len)] == x);
         e_err  = !e_done;
`else
         x = 8'h00;
`endif
      end
   endtask

   task automatic make_frame(input logic [31:0] len, input bit corrupt, output bq_t fr);
      logic [7:0] x, b;
      fr = {};
      fr.push_back(len[7:0]); fr.push_back(len[15:8]);
      fr.push_back(len[23:16]); fr.push_back(len[31:24]);
      x = 8'h00;
      if (len_ok(len)) begin
         for (int k = 0; k < int'(len); k++) begin
            b = 8'($urandom);
            x ^= b;
            fr.push_back(b);
         end
`ifdef IMEM_LOADER_CKSUM_EN
         fr.push_back(corrupt ? x ^ 8'h01 : x);
`endif
      end
   endtask

   task automatic drive(input bq_t fr, input int n, input bit gaps, input int poke);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            int g = 0;
            while ($urandom_range(99) < 50 && g < 8) begin
               s_valid = 1'b0;
               @(posedge clk); #1;
               g++;
            end
         end
         s_valid = 1'b1;
         s_data  = fr[i];
         if (i == poke) start = 1'b1;
         begin
            int t = 0;
            while (!s_ready && t < 50) begin
               @(posedge clk); #1;
               t++;
            end
            if (!s_ready) begin
               check("s_ready_timeout", 64'd0, 64'd1);
               s_valid = 1'b0;
               start = 1'b0;
               return;
            end
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      s_valid = 1'b0;
   endtask

   task automatic run_load(input string name, input bq_t fr, input bit gaps, input int poke);
      int n_acc, n_wr, bad, lat;
      bit e_done, e_err;
      wr_cyc = {}; wr_a = {}; wr_d = {}; acc_cyc = {};
      model(fr, n_acc, n_wr, e_done, e_err);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check({name, ".start_busy"}, 64'(busy), 64'd1);
      check({name, ".start_done"}, 64'(done), 64'd0);
      check({name, ".start_err"},  64'(err), 64'd0);
      check({name, ".start_hold"}, 64'(cpu_hold), 64'd1);
      drive(fr, n_acc, gaps, poke);
      repeat (3) @(posedge clk);
      #1;
      check({name, ".done"},     64'(done), 64'(e_done));
      check({name, ".err"},      64'(err), 64'(e_err));
      check({name, ".hold"},     64'(cpu_hold), 64'(!e_done));
      check({name, ".busy"},     64'(busy), 64'd0);
      check({name, ".s_ready"},  64'(s_ready), 64'd0);
      check({name, ".n_accept"}, 64'(acc_cyc.size()), 64'(n_acc));
      check({name, ".n_writes"}, 64'(wr_a.size()), 64'(n_wr));
      bad = 0; lat = 0;
      for (int k = 0; k < n_wr && k < wr_a.size(); k++) begin
         if (wr_a[k] !== 32'(k) || wr_d[k] !== fr[4+k]) bad++;
         if (4 + k < acc_cyc.size() && wr_cyc[k] != acc_cyc[4+k] + 1) lat++;
      end
      check({name, ".wr_seq_bad"},  64'(bad), 64'd0);
      check({name, ".wr_latency_bad"}, 64'(lat), 64'd0);
   endtask

   initial begin
      bq_t fr, fr2;
      logic [31:0] len;

      n_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.hold",    64'(cpu_hold), 64'd1);
      check("rst.s_ready", 64'(s_ready), 64'd0);
      check("rst.busy",    64'(busy), 64'd0);
      check("rst.done",    64'(done), 64'd0);
      check("rst.err",     64'(err), 64'd0);
      check("rst.wr_en",   64'(wr_en), 64'd0);
      check("rst.wr_addr", 64'(wr_addr), 64'd0);
      n_rst = 1'b1;

      fr = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CKSUM_EN
      fr.push_back(8'h13 ^ 8'h93 ^ 8'h10);
`endif
      run_load("basic", fr, 1'b0, -1);
      check("basic.word4", 64'({ram[7], ram[6], ram[5], ram[4]}), 64'h00100093);
      if (wr_cyc.size() == 8) check("basic.back_to_back", 64'(wr_cyc[7] - wr_cyc[0]), 64'd7);

      fr = '{8'h06, 8'h00, 8'h00, 8'h00};
      run_load("len6", fr, 1'b0, -1);
      fr = '{8'h04, 8'h40, 8'h00, 8'h00};
      run_load("len4004", fr, 1'b0, -1);
      fr = '{8'hFC, 8'hFF, 8'hFF, 8'hFF};
      run_load("lenhuge", fr, 1'b0, -1);

      make_frame(32'd16, 1'b0, fr);
      run_load("p16_nogap", fr, 1'b0, -1);
      run_load("p16_gap", fr, 1'b1, -1);

      make_frame(32'd32, 1'b0, fr);
      run_load("start_mid", fr, 1'b1, 14);

      make_frame(32'd0, 1'b0, fr);
      run_load("len0", fr, 1'b0, -1);

      make_frame(32'(MS), 1'b0, fr);
      run_load("len_max", fr, 1'b0, -1);
      make_frame(32'(MS + 4), 1'b0, fr);
      run_load("len_over", fr, 1'b0, -1);

      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(2) == 0) len = 32'($urandom_range(70));
         else len = 32'($urandom_range(16) * 4);
         make_frame(len, 1'b0, fr2);
         run_load($sformatf("rand%0d", r), fr2, 1'b1, -1);
      end

`ifdef IMEM_LOADER_CKSUM_EN
      fr = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
      run_load("cks_ok", fr, 1'b0, -1);
      fr = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
      run_load("cks_bad", fr, 1'b0, -1);
      make_frame(32'd20, 1'b1, fr);
      run_load("cks_rand_bad", fr, 1'b1, -1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
